calendar_counter: RTL and testbench

Sequential date source that drives the month/leap encoding consumed by the days-per-month decoder: it holds a day/month/year date, advances it on single-day ticks or multi-day advance requests, and exports the month number, leap flag and one-hot month-length class. It is the writer side of the month/leap interface, sitting upstream of any day-count decoding logic in the calendar datapath.

---
 rtl/calendar_counter_if.sv | 34 +++
 rtl/calendar_counter.sv | 145 ++++++++++++++
 tb/tb_calendar_counter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calendar_counter_if.sv
// Month/leap date interface between the calendar counter (slave) and its user (master).
interface calendar_counter_if #(
  parameter int YEAR_W = 12
);
  logic              tick;
  logic              load;
  logic [4:0]        ld_day;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;
  logic              adv_valid;
  logic [7:0]        adv_days;
  logic              adv_ready;
  logic              adv_done;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              m28, m29, m30, m31;
  logic              month_end;
  logic              year_end;
  logic              load_err;

  modport master (
    output tick, load, ld_day, ld_month, ld_year, adv_valid, adv_days,
    input  adv_ready, adv_done, day, month, year, leap, m28, m29, m30, m31,
           month_end, year_end, load_err
  );

  modport slave (
    input  tick, load, ld_day, ld_month, ld_year, adv_valid, adv_days,
    output adv_ready, adv_done, day, month, year, leap, m28, m29, m30, m31,
           month_end, year_end, load_err
  );
endinterface

// File: rtl/calendar_counter.sv
// Day/month/year date register with single-day ticks, validated loads and a multi-day advance FSM.
// Define CALENDAR_GREGORIAN_EN for the Gregorian leap rule; the default build uses the Julian rule.
//
// state | meaning
// IDLE  | ready for a new advance request; ticks are honoured
// STEP  | one day step per cycle until rem is exhausted
// DONE  | advance finished; adv_done is raised on the way back to IDLE
module calendar_counter #(
  parameter int YEAR_W     = 12,
  parameter int RESET_YEAR = 2000
) (
  input  logic               clk,
  input  logic               rst,
  calendar_counter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q;
  logic [7:0]        rem_q;
  logic [4:0]        day_q;
  logic [3:0]        month_q;
  logic [YEAR_W-1:0] year_q;
  logic              adv_done_q;
  logic              month_end_q;
  logic              year_end_q;
  logic              load_err_q;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
`ifdef CALENDAR_GREGORIAN_EN
    int yi;
    yi = int'(y);
    is_leap = ((yi % 4) == 0 && (yi % 100) != 0) || (yi % 400) == 0;
`else
    is_leap = (y[1:0] == 2'b00);
`endif
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                     month_len = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  month_len = 5'd30;
      default:                  month_len = 5'd31;
    endcase
  endfunction

  logic              leap_cur;
  logic [4:0]        len_cur;
  logic              last_day;
  logic              last_month;
  logic [4:0]        nxt_day;
  logic [3:0]        nxt_month;
  logic [YEAR_W-1:0] nxt_year;
  logic              load_ok;
  logic              step_en;

  always_comb begin
    leap_cur   = is_leap(year_q);
    len_cur    = month_len(month_q, leap_cur);
    last_day   = (day_q >= len_cur);
    last_month = (month_q == 4'd12);
    nxt_day    = last_day ? 5'd1 : day_q + 5'd1;
    nxt_month  = month_q;
    nxt_year   = year_q;
    if (last_day) begin
      nxt_month = last_month ? 4'd1 : month_q + 4'd1;
      if (last_month) nxt_year = year_q + 1'b1;  // wraps at 2^YEAR_W
    end
    load_ok = (bus.ld_month >= 4'd1) && (bus.ld_month <= 4'd12) && (bus.ld_day >= 5'd1) &&
              (bus.ld_day <= month_len(bus.ld_month, is_leap(bus.ld_year)));
    // A STEP-state step outranks tick; ticks outside IDLE are dropped.
    step_en = !bus.load && ((state_q == STEP) || (state_q == IDLE && bus.tick));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 8'd0;
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      year_q      <= YEAR_W'(RESET_YEAR);
      adv_done_q  <= 1'b0;
      month_end_q <= 1'b0;
      year_end_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      adv_done_q  <= 1'b0;
      month_end_q <= 1'b0;
      year_end_q  <= 1'b0;
      load_err_q  <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          day_q   <= bus.ld_day;
          month_q <= bus.ld_month;
          year_q  <= bus.ld_year;
        end else begin
          load_err_q <= 1'b1;
        end
        state_q <= IDLE;
      end else begin
        if (step_en) begin
          day_q       <= nxt_day;
          month_q     <= nxt_month;
          year_q      <= nxt_year;
          month_end_q <= last_day;
          year_end_q  <= last_day && last_month;
        end
        case (state_q)
          IDLE: begin
            if (bus.adv_valid) begin
              rem_q   <= bus.adv_days;
              state_q <= (bus.adv_days == 8'd0) ? DONE : STEP;
            end
          end
          STEP: begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= DONE;
          end
          DONE: begin
            adv_done_q <= 1'b1;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.adv_ready = (state_q == IDLE);
  assign bus.adv_done  = adv_done_q;
  assign bus.day       = day_q;
  assign bus.month     = month_q;
  assign bus.year      = year_q;
  assign bus.leap      = leap_cur;
  assign bus.m28       = (len_cur == 5'd28);
  assign bus.m29       = (len_cur == 5'd29);
  assign bus.m30       = (len_cur == 5'd30);
  assign bus.m31       = (len_cur == 5'd31);
  assign bus.month_end = month_end_q;
  assign bus.year_end  = year_end_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench for calendar_counter against a plain-arithmetic date model.
module tb_calendar_counter;
  localparam int YW   = 12;
  localparam int YMOD = 1 << YW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calendar_counter_if #(.YEAR_W(YW)) bif ();

  calendar_counter #(.YEAR_W(YW), .RESET_YEAR(2000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks   = 0;
  int failures = 0;
  int md, mm, my;

  function automatic bit model_leap(int y);
`ifdef CALENDAR_GREGORIAN_EN
    return ((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0;
`else
    return (y % 4) == 0;
`endif
  endfunction

  function automatic int mdays(int m, int y);
    if (m == 2) return model_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_step(output bit me, output bit ye);
    me = 0;
    ye = 0;
    if (md < mdays(mm, my)) md++;
    else begin
      md = 1;
      me = 1;
      if (mm == 12) begin
        mm = 1;
        ye = 1;
        my = (my + 1) % YMOD;
      end else mm++;
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int d, input int m, input int y);
    bif.ld_day   = 5'(d);
    bif.ld_month = 4'(m);
    bif.ld_year  = YW'(y);
    bif.load     = 1'b1;
    cyc();
    bif.load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    md = 1; mm = 1; my = 2000;
    checks++;
    if ({bif.day, bif.month, bif.year} !== {5'd1, 4'd1, 12'd2000}) begin
      failures++;
      $display("FAIL reset_date got %0d/%0d/%0d want 1/1/2000", bif.day, bif.month, bif.year);
    end
    checks++;
    if ({bif.leap, bif.m31, bif.m30, bif.m29, bif.m28} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_len got leap=%b m31..m28=%b%b%b%b want 1 1000", bif.leap, bif.m31, bif.m30, bif.m29, bif.m28);
    end
    checks++;
    if ({bif.adv_ready, bif.adv_done, bif.month_end, bif.year_end, bif.load_err} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got %b%b%b%b%b want 10000", bif.adv_ready, bif.adv_done, bif.month_end, bif.year_end, bif.load_err);
    end
  endtask

  task automatic test_ticks;
    bit me, ye;
    int me_cnt = 0;
    bif.tick = 1'b1;
    for (int i = 0; i < 31; i++) begin
      cyc();
      model_step(me, ye);
      if (bif.month_end) me_cnt++;
      checks++;
      if ({bif.day, bif.month, bif.year, bif.month_end} !== {5'(md), 4'(mm), 12'(my), me}) begin
        failures++;
        $display("FAIL tick_step got %0d/%0d/%0d me=%b want %0d/%0d/%0d me=%b", bif.day, bif.month, bif.year, bif.month_end, md, mm, my, me);
      end
    end
    bif.tick = 1'b0;
    checks++;
    if ({bif.day, bif.month, bif.year} !== {5'd1, 4'd2, 12'd2000} || me_cnt != 1) begin
      failures++;
      $display("FAIL tick_31 got %0d/%0d/%0d pulses=%0d want 1/2/2000 pulses=1", bif.day, bif.month, bif.year, me_cnt);
    end
    checks++;
    if ({bif.leap, bif.m28, bif.m29} !== 3'b101) begin
      failures++;
      $display("FAIL tick_feb got leap=%b m28=%b m29=%b want 1 0 1", bif.leap, bif.m28, bif.m29);
    end
    cyc();
    checks++;
    if (bif.month_end !== 1'b0) begin
      failures++;
      $display("FAIL tick_pulse got month_end=%b want 0", bif.month_end);
    end
  endtask

  task automatic test_random_ticks;
    bit me, ye, t;
    int len;
    do_load(25, 12, 2099);
    md = 25; mm = 12; my = 2099;
    for (int i = 0; i < 60; i++) begin
      t = 1'($urandom_range(0, 1));
      bif.tick = t;
      cyc();
      me = 0; ye = 0;
      if (t) model_step(me, ye);
      len = mdays(mm, my);
      checks++;
      if ({bif.day, bif.month, bif.year, bif.month_end, bif.year_end} !== {5'(md), 4'(mm), 12'(my), me, ye}) begin
        failures++;
        $display("FAIL rand_tick got %0d/%0d/%0d me=%b ye=%b want %0d/%0d/%0d me=%b ye=%b", bif.day, bif.month, bif.year, bif.month_end, bif.year_end, md, mm, my, me, ye);
      end
      checks++;
      if ({bif.leap, bif.m31, bif.m30, bif.m29, bif.m28} !== {model_leap(my), len == 31, len == 30, len == 29, len == 28}) begin
        failures++;
        $display("FAIL rand_len got leap=%b m31..m28=%b%b%b%b want len %0d", bif.leap, bif.m31, bif.m30, bif.m29, bif.m28, len);
      end
    end
    bif.tick = 1'b0;
  endtask

  task automatic test_century_and_wrap;
    bit me, ye;
    do_load(28, 2, 1900);
    md = 28; mm = 2; my = 1900;
    bif.tick = 1'b1;
    cyc();
    bif.tick = 1'b0;
    model_step(me, ye);
    checks++;
    if ({bif.day, bif.month, bif.year} !== {5'(md), 4'(mm), 12'(my)}) begin
      failures++;
      $display("FAIL century got %0d/%0d/%0d want %0d/%0d/%0d", bif.day, bif.month, bif.year, md, mm, my);
    end
    do_load(31, 12, YMOD - 1);
    checks++;
    if ({bif.month_end, bif.year_end, bif.load_err} !== 3'b000) begin
      failures++;
      $display("FAIL load_no_pulse got me=%b ye=%b err=%b want 000", bif.month_end, bif.year_end, bif.load_err);
    end
    bif.tick = 1'b1;
    cyc();
    bif.tick = 1'b0;
    md = 1; mm = 1; my = 0;
    checks++;
    if ({bif.day, bif.month, bif.year, bif.year_end, bif.month_end, bif.leap} !== {5'd1, 4'd1, 12'd0, 3'b111}) begin
      failures++;
      $display("FAIL year_wrap got %0d/%0d/%0d ye=%b me=%b leap=%b want 1/1/0 111", bif.day, bif.month, bif.year, bif.year_end, bif.month_end, bif.leap);
    end
  endtask

  task automatic test_load_validation;
    int d, m, y;
    bit ok;
    do_load(31, 4, 2001);
    checks++;
    if ({bif.load_err, bif.day, bif.month, bif.year} !== {1'b1, 5'd1, 4'd1, 12'd0}) begin
      failures++;
      $display("FAIL load_31apr got err=%b %0d/%0d/%0d want err=1 1/1/0", bif.load_err, bif.day, bif.month, bif.year);
    end
    cyc();
    checks++;
    if (bif.load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse got %b want 0", bif.load_err);
    end
    do_load(29, 2, 2001);
    checks++;
    if ({bif.load_err, bif.day, bif.month, bif.year} !== {1'b1, 5'd1, 4'd1, 12'd0}) begin
      failures++;
      $display("FAIL load_29feb2001 got err=%b %0d/%0d/%0d want err=1 1/1/0", bif.load_err, bif.day, bif.month, bif.year);
    end
    do_load(29, 2, 2004);
    md = 29; mm = 2; my = 2004;
    checks++;
    if ({bif.load_err, bif.day, bif.month, bif.year} !== {1'b0, 5'd29, 4'd2, 12'd2004}) begin
      failures++;
      $display("FAIL load_29feb2004 got err=%b %0d/%0d/%0d want err=0 29/2/2004", bif.load_err, bif.day, bif.month, bif.year);
    end
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 31);
      m = $urandom_range(0, 15);
      y = $urandom_range(0, YMOD - 1);
      ok = (m >= 1 && m <= 12 && d >= 1 && d <= mdays(m, y));
      do_load(d, m, y);
      if (ok) begin md = d; mm = m; my = y; end
      checks++;
      if ({bif.load_err, bif.day, bif.month, bif.year} !== {!ok, 5'(md), 4'(mm), 12'(my)}) begin
        failures++;
        $display("FAIL rand_load %0d/%0d/%0d got err=%b %0d/%0d/%0d want err=%b %0d/%0d/%0d", d, m, y, bif.load_err, bif.day, bif.month, bif.year, !ok, md, mm, my);
      end
    end
  endtask

  // Runs one advance of n days; ticks during the advance must be dropped.
  task automatic run_advance(input string name, input int n, input bit tick_at_accept, input bit tick_during);
    bit me, ye, got;
    int ready_low = 0;
    bif.adv_valid = 1'b1;
    bif.adv_days  = 8'(n);
    bif.tick      = tick_at_accept;
    cyc();
    if (tick_at_accept) model_step(me, ye);
    for (int i = 0; i < n; i++) model_step(me, ye);
    bif.adv_valid = 1'b0;
    bif.tick = tick_during;
    if (!bif.adv_ready) ready_low++;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      cyc();
      if (!bif.adv_ready) ready_low++;
      if (bif.adv_done) got = 1;
      bif.tick = tick_during & 1'($urandom_range(0, 1));
    end
    bif.tick = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout got no adv_done want adv_done within 400 cycles", name);
    end
    // ready stays low through the DONE cycle as well, hence n+1.
    checks++;
    if (ready_low != n + 1) begin
      failures++;
      $display("FAIL %s ready_low got %0d want %0d", name, ready_low, n + 1);
    end
    checks++;
    if ({bif.day, bif.month, bif.year, bif.adv_ready} !== {5'(md), 4'(mm), 12'(my), 1'b1}) begin
      failures++;
      $display("FAIL %s date got %0d/%0d/%0d ready=%b want %0d/%0d/%0d ready=1", name, bif.day, bif.month, bif.year, bif.adv_ready, md, mm, my);
    end
    cyc();
    checks++;
    if (bif.adv_done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse got %b want 0", name, bif.adv_done);
    end
  endtask

  task automatic test_advance;
    do_load(1, 1, 2000);
    md = 1; mm = 1; my = 2000;
    run_advance("adv60", 60, 1'b0, 1'b1);
    checks++;
    if ({bif.day, bif.month, bif.year} !== {5'd1, 4'd3, 12'd2000}) begin
      failures++;
      $display("FAIL adv60_final got %0d/%0d/%0d want 1/3/2000", bif.day, bif.month, bif.year);
    end
    run_advance("adv0", 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_advance("adv_rand", $urandom_range(1, 200), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_abort;
    int done_cnt = 0;
    do_load(1, 1, 2000);
    bif.adv_valid = 1'b1;
    bif.adv_days  = 8'd100;
    cyc();
    bif.adv_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    do_load(15, 6, 2010);
    md = 15; mm = 6; my = 2010;
    checks++;
    if ({bif.day, bif.month, bif.year, bif.adv_ready, bif.month_end} !== {5'd15, 4'd6, 12'd2010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL abort_load got %0d/%0d/%0d ready=%b me=%b want 15/6/2010 ready=1 me=0", bif.day, bif.month, bif.year, bif.adv_ready, bif.month_end);
    end
    for (int i = 0; i < 110; i++) begin
      cyc();
      if (bif.adv_done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || {bif.day, bif.month, bif.year} !== {5'd15, 4'd6, 12'd2010}) begin
      failures++;
      $display("FAIL abort_quiet got done=%0d %0d/%0d/%0d want done=0 15/6/2010", done_cnt, bif.day, bif.month, bif.year);
    end
  endtask

  initial begin
    bif.tick = 1'b0;
    bif.load = 1'b0;
    bif.ld_day = '0;
    bif.ld_month = '0;
    bif.ld_year = '0;
    bif.adv_valid = 1'b0;
    bif.adv_days = '0;
    test_reset();
    test_ticks();
    test_random_ticks();
    test_century_and_wrap();
    test_load_validation();
    test_advance();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
